ram_arbiter: RTL and testbench

Two-port arbiter that shares the CPU's single-port 256×8 synchronous RAM between the CPU memory interface (driven by the microcoded control unit's MO/MI/MAI steps) and the program loader. It serialises requests, issues exactly one RAM access per grant and returns an acknowledge with read data. It alternates fairly when both sides contend, and it lets the loader lock the CPU out and halt it while a program image is written.

---
 rtl/ram_arbiter_pkg.sv | 23 ++
 rtl/ram_arbiter_rr2.sv | 42 ++++
 rtl/ram_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM states, port ids and widths.
// Imported by the arbiter top and its round-robin picker.
package ram_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_LDR = 1'b1;

  function automatic logic [1:0] port_mask(port_id_t p);
    return (p == PORT_LDR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr2.sv
// Two-input round-robin picker with last-owner pointer.
// Masked inputs are never granted; ties go to the port not granted last.
module arb_rr2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       take_i,
  output logic       gnt_valid_o,
  output port_id_t   gnt_id_o
);

  port_id_t   last_q;
  port_id_t   last_d;
  logic [1:0] elig;

  always_comb begin
    elig        = req_i & ~mask_i;
    gnt_valid_o = |elig;
    gnt_id_o    = PORT_CPU;
    if (elig == 2'b11) begin
      gnt_id_o = ~last_q;
    end else if (elig[PORT_LDR]) begin
      gnt_id_o = PORT_LDR;
    end
    last_d = last_q;
    if (take_i && gnt_valid_o) begin
      last_d = gnt_id_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_LDR;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between the CPU bus and the program loader.
// One RAM access per grant; the loader may lock out and halt the CPU.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_halt,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  input  logic                  ldr_lock,
  output logic                  ldr_ack,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  arb_state_e            state_q;
  arb_state_e            state_d;
  port_id_t              owner_q;
  port_id_t              owner_d;
  logic                  we_q;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  lock_q;
  logic                  lock_d;
  logic                  halt_q;
  logic                  halt_d;

  logic [1:0] req_vec;
  logic [1:0] mask_vec;
  logic       take;
  logic       gnt_valid;
  port_id_t   gnt_id;
  logic       cpu_next_busy;
  logic       resp;

  always_comb begin
    req_vec  = {ldr_req, cpu_req & ~halt_q};
    mask_vec = (state_q == ARB_RESP) ? port_mask(owner_q) : 2'b00;
    take     = (state_q != ARB_ACCESS);
  end

  arb_rr2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_vec),
    .mask_i      (mask_vec),
    .take_i      (take),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ARB_IDLE, ARB_RESP: begin
        state_d = ARB_IDLE;
        if (gnt_valid) begin
          state_d = ARB_ACCESS;
          owner_d = gnt_id;
          if (gnt_id == PORT_LDR) begin
            we_d    = ldr_we;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ARB_ACCESS: state_d = ARB_RESP;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // halt only once no CPU access will be in flight after this edge
  always_comb begin
    cpu_next_busy = (state_d != ARB_IDLE) && (owner_d == PORT_CPU);
    lock_d        = ldr_lock;
    halt_d        = lock_q & ~cpu_next_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= PORT_LDR;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lock_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lock_q  <= lock_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    ram_en    = (state_q == ARB_ACCESS);
    ram_we    = ram_en & we_q;
    ram_addr  = ram_en ? addr_q : '0;
    ram_wdata = ram_en ? wdata_q : '0;
    resp      = (state_q == ARB_RESP);
    cpu_ack   = resp && (owner_q == PORT_CPU);
    ldr_ack   = resp && (owner_q == PORT_LDR);
    cpu_rdata = cpu_ack ? ram_rdata : '0;
    ldr_rdata = ldr_ack ? ram_rdata : '0;
    cpu_halt  = halt_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 256x8 RAM.
// Directed traffic pushes expected acks; a negedge monitor pops them.
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       cpu_halt;
  logic       ldr_req;
  logic       ldr_we;
  logic [7:0] ldr_addr;
  logic [7:0] ldr_wdata;
  logic       ldr_lock;
  logic       ldr_ack;
  logic [7:0] ldr_rdata;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic       chk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] mem [256] = '{default: 8'h00};
  logic       preloaded = 1'b0;

  logic       en_tab   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] addr_tab [6] = '{8'h0E, 8'h00, 8'h10, 8'h00, 8'h0E, 8'h00};

  ram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_halt  (cpu_halt),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_lock  (ldr_lock),
    .ldr_ack   (ldr_ack),
    .ldr_rdata (ldr_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!preloaded) begin
      mem[8'h0E] <= 8'h2A;
      mem[8'h10] <= 8'h77;
      preloaded  <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_ack(input logic port, input logic [7:0] data,
                            input logic chk);
    exp_t e;
    e.port = port;
    e.data = data;
    e.chk  = chk;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input logic port, input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? ldr_ack : cpu_ack) begin
        if (port) ldr_req = 1'b0;
        else      cpu_req = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s timeout got=no_ack want=ack", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("ack_overlap", 32'(cpu_ack & ldr_ack), 32'd0);
      if (cpu_ack ^ ldr_ack) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL ack_unexpected got=ack want=none");
        end else begin
          mon_e = sb.pop_front();
          if (ldr_ack !== mon_e.port) begin
            failures++;
            $display("FAIL ack_port got=%0d want=%0d", ldr_ack, mon_e.port);
          end
          if (mon_e.chk) begin
            check("ack_rdata", 32'(ldr_ack ? ldr_rdata : cpu_rdata),
                  32'(mon_e.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_seen;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    ldr_req   = 1'b0;
    ldr_we    = 1'b0;
    ldr_addr  = 8'h00;
    ldr_wdata = 8'h00;
    ldr_lock  = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_ctrl", 32'({ram_en, cpu_ack, ldr_ack, cpu_halt, ram_we}), 32'd0);
    check("rst_data", {ram_addr, ram_wdata, cpu_rdata, ldr_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // CPU read alone
    cpu_req  = 1'b1;
    cpu_addr = 8'h0E;
    expect_ack(1'b0, 8'h2A, 1'b1);
    @(negedge clk);
    check("t1_ram_en", 32'(ram_en), 32'd1);
    check("t1_ram_addr", 32'(ram_addr), 32'h0E);
    check("t1_ram_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    check("t1_cpu_ack", 32'(cpu_ack), 32'd1);
    check("t1_ldr_ack", 32'(ldr_ack), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("t1_idle", 32'(ram_en), 32'd0);

    // contention straight out of reset
    rst      = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 8'h0E;
    ldr_req  = 1'b1;
    ldr_addr = 8'h10;
    expect_ack(1'b0, 8'h2A, 1'b1);
    expect_ack(1'b1, 8'h77, 1'b1);
    expect_ack(1'b0, 8'h2A, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t2_en_%0d", c), 32'(ram_en), 32'(en_tab[c]));
      if (en_tab[c]) begin
        check($sformatf("t2_addr_%0d", c), 32'(ram_addr), 32'(addr_tab[c]));
      end
      if (c == 5) begin
        cpu_req = 1'b0;
        ldr_req = 1'b0;
      end
    end
    @(negedge clk);
    check("t2_idle", 32'(ram_en), 32'd0);

    // loader write, then CPU read-back
    ldr_req   = 1'b1;
    ldr_we    = 1'b1;
    ldr_addr  = 8'h0F;
    ldr_wdata = 8'h55;
    expect_ack(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    check("t3_ram_en", 32'(ram_en), 32'd1);
    check("t3_ram_we", 32'(ram_we), 32'd1);
    check("t3_ram_addr", 32'(ram_addr), 32'h0F);
    check("t3_ram_wdata", 32'(ram_wdata), 32'h55);
    wait_ack(1'b1, "t3_ldr_ack");
    ldr_we   = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h0F;
    expect_ack(1'b0, 8'h55, 1'b1);
    wait_ack(1'b0, "t3_cpu_ack");
    @(negedge clk);

    // lock raised during a CPU access
    cpu_req  = 1'b1;
    cpu_addr = 8'h0E;
    expect_ack(1'b0, 8'h2A, 1'b1);
    @(negedge clk);
    check("t4_ram_en", 32'(ram_en), 32'd1);
    ldr_lock = 1'b1;
    @(negedge clk);
    check("t4_cpu_ack", 32'(cpu_ack), 32'd1);
    check("t4_halt_low", 32'(cpu_halt), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("t4_halt_rise", 32'(cpu_halt), 32'd1);
    ldr_req  = 1'b1;
    ldr_addr = 8'h0F;
    expect_ack(1'b1, 8'h55, 1'b1);
    wait_ack(1'b1, "t4_ldr_ack");
    cpu_req  = 1'b1;
    cpu_addr = 8'h0E;
    expect_ack(1'b0, 8'h2A, 1'b1);
    en_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      en_seen = en_seen | ram_en;
    end
    check("t4_blocked", 32'(en_seen), 32'd0);
    check("t4_halt_hold", 32'(cpu_halt), 32'd1);
    ldr_lock = 1'b0;
    @(negedge clk);
    check("t4_halt_d1", 32'(cpu_halt), 32'd1);
    check("t4_en_d1", 32'(ram_en), 32'd0);
    @(negedge clk);
    check("t4_halt_d2", 32'(cpu_halt), 32'd0);
    check("t4_en_d2", 32'(ram_en), 32'd0);
    @(negedge clk);
    check("t4_en_d3", 32'(ram_en), 32'd1);
    check("t4_addr_d3", 32'(ram_addr), 32'h0E);
    wait_ack(1'b0, "t4_cpu_ack2");
    @(negedge clk);

    // reset while the loader's ack is up
    ldr_req  = 1'b1;
    ldr_addr = 8'h10;
    @(negedge clk);
    check("t5_ram_en", 32'(ram_en), 32'd1);
    @(posedge clk);
    #1;
    check("t5_pre_ack", 32'(ldr_ack), 32'd1);
    rst     = 1'b1;
    ldr_req = 1'b0;
    #1;
    check("t5_rst_ctrl", 32'({ram_en, cpu_ack, ldr_ack, cpu_halt, ram_we}), 32'd0);
    check("t5_rst_data", {ram_addr, ram_wdata, cpu_rdata, ldr_rdata}, 32'd0);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 8'h0E;
    ldr_req  = 1'b1;
    ldr_addr = 8'h10;
    expect_ack(1'b0, 8'h2A, 1'b1);
    expect_ack(1'b1, 8'h77, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_tie_en", 32'(ram_en), 32'd1);
    check("t5_tie_cpu", 32'(ram_addr), 32'h0E);
    wait_ack(1'b0, "t5_cpu_ack");
    wait_ack(1'b1, "t5_ldr_ack");
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
